// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_display_ctrl
//  Purpose  : Arbitrates between a keyboard stream and a system write port,
//             maintains an 8-character buffer (index 7 = leftmost digit) and
//             refreshes the whole 8-digit display after every update with a
//             paced sweep of single-cycle writes (idx 7 down to 0).
//  Ports    : clk, reset          - clock and synchronous active-high reset
//             kb_valid, kb_ascii  - one-cycle key strobe and key character
//             sys_req, sys_id,    - level request to write sys_ascii into
//             sys_ascii             digit sys_id (held until sys_ack)
//             sys_ack             - one-cycle grant pulse for sys_req
//             disp_en, disp_id,   - one-cycle write strobe, digit index and
//             disp_ascii            character toward the display driver
//             busy                - a sweep is in progress
//             kb_overflow         - sticky: a key was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_valid,
    input  logic [7:0] kb_ascii,
    input  logic       sys_req,
    input  logic [2:0] sys_id,
    input  logic [7:0] sys_ascii,
    output logic       sys_ack,
    output logic       disp_en,
    output logic [2:0] disp_id,
    output logic [7:0] disp_ascii,
    output logic       busy,
    output logic       kb_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] c_BACKSPACE = 8'h08;
    localparam logic       c_GRANT_KB  = 1'b0;
    localparam logic       c_GRANT_SYS = 1'b1;
    // Last count value of the GAP state; unused when GAP_CYCLES is 0.
    localparam logic [7:0] c_GAP_LAST  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_buf [8];
    logic       r_kb_pend;
    logic [7:0] r_kb_hold;
    logic       r_kb_overflow;
    logic       r_last_grant;
    logic [2:0] r_idx;
    logic [7:0] r_gap_cnt;

    logic       w_grant_sys;
    logic       w_grant_kb;
    logic       w_kb_load;
    logic       w_kb_drop;
    logic       w_write_active;

    // ------------------------------------------------------------------
    // Next-state / grant logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_sys = 1'b0;
        w_grant_kb  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sys_req && r_kb_pend) begin
                    // Tie: alternate, favouring whoever was not served last.
                    if (r_last_grant == c_GRANT_SYS) begin
                        w_grant_kb = 1'b1;
                    end else begin
                        w_grant_sys = 1'b1;
                    end
                end else if (sys_req) begin
                    w_grant_sys = 1'b1;
                end else if (r_kb_pend) begin
                    w_grant_kb = 1'b1;
                end
                if (w_grant_sys || w_grant_kb) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_idx == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end else if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_WRITE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A key slot freed by a keyboard grant this cycle can take a new key.
    assign w_kb_load = kb_valid && (!r_kb_pend || w_grant_kb);
    assign w_kb_drop = kb_valid && r_kb_pend && !w_grant_kb;

    // ------------------------------------------------------------------
    // State, index and gap counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd7;
            r_gap_cnt    <= 8'd0;
            r_last_grant <= c_GRANT_KB;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_sys || w_grant_kb) begin
                r_idx <= 3'd7;
            end else if (r_state == S_WRITE && r_idx != 3'd0) begin
                r_idx <= r_idx - 3'd1;
            end

            if (r_state == S_GAP && w_state_nxt == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end else begin
                r_gap_cnt <= 8'd0;
            end

            if (w_grant_sys) begin
                r_last_grant <= c_GRANT_SYS;
            end else if (w_grant_kb) begin
                r_last_grant <= c_GRANT_KB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Keyboard pending slot and sticky overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kb_pend     <= 1'b0;
            r_kb_hold     <= 8'd0;
            r_kb_overflow <= 1'b0;
        end else begin
            if (w_kb_load) begin
                r_kb_pend <= 1'b1;
                r_kb_hold <= kb_ascii;
            end else if (w_grant_kb) begin
                r_kb_pend <= 1'b0;
            end
            if (w_kb_drop) begin
                r_kb_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= BLANK_CHAR;
            end
        end else if (w_grant_sys) begin
            r_buf[sys_id] <= sys_ascii;
        end else if (w_grant_kb) begin
            if (r_kb_hold == c_BACKSPACE) begin
                // Backspace: everything moves right, a blank enters on the left.
                for (int i = 0; i < 7; i++) begin
                    r_buf[i] <= r_buf[i + 1];
                end
                r_buf[7] <= BLANK_CHAR;
            end else begin
                // New character enters on the right; leftmost falls off.
                for (int i = 0; i < 7; i++) begin
                    r_buf[i + 1] <= r_buf[i];
                end
                r_buf[0] <= r_kb_hold;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: forced quiet while reset is asserted so an aborted sweep
    // produces no further strobes even before the reset edge.
    // ------------------------------------------------------------------
    assign w_write_active = (r_state == S_WRITE) && !reset;
    assign disp_en        = w_write_active;
    assign disp_id        = w_write_active ? r_idx : 3'd0;
    assign disp_ascii     = w_write_active ? r_buf[r_idx] : 8'd0;
    assign sys_ack        = w_grant_sys && !reset;
    assign busy           = (r_state != S_IDLE) && !reset;
    assign kb_overflow    = r_kb_overflow;

endmodule
`default_nettype wire

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles between successive digit writes (legal 0..255).
REQ-002 SHALL have parameter BLANK_CHAR, default 8'h20, meaning the character loaded into every digit at reset and shifted in by backspace.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports kb_valid  input  1 (one-cycle new-key strobe) and kb_ascii  input  8 (key character, valid with kb_valid).
REQ-006 SHALL have ports sys_req  input  1, sys_id  input  3, sys_ascii  input  8: level request to write sys_ascii into digit sys_id; inputs held stable until ack.
REQ-007 SHALL have port sys_ack  output  1  one-cycle pulse on the cycle a system request is granted.
REQ-008 SHALL have ports disp_en  output  1, disp_id  output  3, disp_ascii  output  8: one-cycle write strobe, digit index (7 = leftmost), character, toward the 8-digit display driver.
REQ-009 SHALL have ports busy  output  1 (state != IDLE) and kb_overflow  output  1 (sticky dropped-key flag).

Function
REQ-010 SHALL hold an 8-entry x 8-bit character buffer buf[7:0], index 7 leftmost.
REQ-011 SHALL hold one keyboard pending slot (kb_pend, kb_hold); kb_valid with slot empty, or being consumed that same cycle, loads kb_ascii and sets kb_pend.
REQ-012 SHALL drop kb_valid arriving while kb_pend=1 and not consumed that cycle, setting kb_overflow=1 until reset.
REQ-013 SHALL implement states IDLE, WRITE, GAP.
REQ-014 IDLE: with only one requester pending (sys_req=1 or kb_pend=1), SHALL grant it; with both pending, SHALL grant the one not granted last (round-robin, last_grant reset to keyboard so system wins first tie).
REQ-015 System grant SHALL write buf[sys_id]<=sys_ascii, pulse sys_ack that cycle, go WRITE with idx=7.
REQ-016 Keyboard grant with kb_hold=8'h08 SHALL shift right: buf[i]<=buf[i+1] for i=0..6, buf[7]<=BLANK_CHAR.
REQ-017 Keyboard grant with any other code SHALL shift left: buf[i+1]<=buf[i] for i=0..6, buf[0]<=kb_hold; old buf[7] discarded.
REQ-018 Keyboard grant SHALL clear kb_pend (subject to REQ-011) and go WRITE with idx=7.
REQ-019 WRITE: disp_en=1, disp_id=idx, disp_ascii=buf[idx] for exactly one cycle; if idx=0 go IDLE, else idx<=idx-1 and go GAP (or WRITE directly if GAP_CYCLES=0).
REQ-020 GAP: count GAP_CYCLES cycles with disp_en=0, then WRITE.
REQ-021 A sweep SHALL be 8 writes, idx 7 down to 0, spaced exactly GAP_CYCLES+1 cycles apart; it is never interrupted; requests arriving during a sweep wait (sys_req) or are held (keyboard, REQ-011/012).
REQ-022 Latency: kb_valid at edge t (IDLE, no sys_req) -> grant at edge t+1 -> first disp_en high in cycle after edge t+1; sys_req seen at IDLE edge t -> sys_ack cycle t, first disp_en cycle t+1.
REQ-023 disp_id/disp_ascii SHALL be 0 whenever disp_en=0; sys_ack SHALL never assert outside IDLE.
REQ-024 busy SHALL be 1 from the cycle after grant through the last WRITE cycle inclusive.

Reset
REQ-025 reset=1 SHALL, at the next edge, set state IDLE, all buf entries BLANK_CHAR, kb_pend=0, kb_overflow=0, last_grant=keyboard, idx=7, GAP counter 0.
REQ-026 During and after reset: disp_en=0, disp_id=0, disp_ascii=0, sys_ack=0, busy=0; reset mid-sweep SHALL abort with no further writes.
REQ-027 kb_valid or sys_req asserted while reset=1 SHALL be ignored.

Verification
REQ-028 After reset, kb_valid with 8'h41 -> one sweep: 8 writes ids 7..0, chars 20,20,20,20,20,20,20,41, spaced 5 cycles (GAP_CYCLES=4).
REQ-029 Keys 'A','B' then 8'h08 -> final sweep shows buf 20,20,20,20,20,20,20,41; keys 'A'..'I' (9 keys, spaced past sweeps) -> leftmost 'B', rightmost 'I'.
REQ-030 sys_req id=3 ascii 8'h35 simultaneous with pending key 'C' at IDLE -> sys_ack first, sweep with buf[3]=35, then key sweep with buf[0]=43, buf[4]=35.
REQ-031 Three kb_valid pulses during one sweep -> first held and swept afterwards, second held only if first already consumed, else dropped; kb_overflow=1 and stays 1 until reset.
REQ-032 reset asserted at 3rd write of a sweep -> no disp_en after reset, all outputs 0, subsequent key sweep shows 7 blanks plus the key.
REQ-033 GAP_CYCLES=0 build -> 8 consecutive disp_en cycles ids 7..0, busy low the cycle after id 0.
